// File: rtl/qnn_pkg.sv
// Shared definitions for the quantised dense layer: FSM state codes, width helpers,
// saturating add and the ReLU/saturating requantiser.
package qnn_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StMac   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StEmit  = 2'd3;

   // Number of x beats needed to cover n inputs with the given lane count.
   function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

   // Counter width able to index 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Signed add clamped to the w-bit two's-complement range (w <= 32).
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int unsigned        w);
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (s > hi) return 32'(hi);
      if (s < lo) return 32'(lo);
      return 32'(s);
   endfunction

   // Arithmetic shift down, optional round-half-up, then ReLU and clamp to xw bits.
   function automatic logic [31:0] requant(input logic signed [31:0] acc,
                                           input int unsigned        acc_w,
                                           input int unsigned        shift,
                                           input int unsigned        xw,
                                           input logic               round_en);
      logic signed [31:0] v;
      logic signed [31:0] y;
      logic signed [31:0] ymax;
      v = acc;
      if (round_en) v = sat_add(acc, 32'sd1 <<< (shift - 1), acc_w);
      y    = v >>> shift;
      ymax = (32'sd1 <<< xw) - 32'sd1;
      if (y < 32'sd0) return '0;
      if (y > ymax) return ymax;
      return y;
   endfunction

endpackage

// File: rtl/qnn_mac_lane.sv
// One output neuron: registers the lane products of an accepted beat, sums them on the
// following cycle into a saturating accumulator, and loads the shifted bias on request.
module qnn_mac_lane
   import qnn_pkg::*;
#(
   parameter int unsigned IN_LANES   = 4,
   parameter int unsigned XW         = 4,
   parameter int unsigned WW         = 4,
   parameter int unsigned ACC_W      = 18,
   parameter int unsigned BIAS_SHIFT = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       bias_load_i,
   input  logic [WW-1:0]              bias_i,
   input  logic                       beat_i,
   input  logic [IN_LANES*XW-1:0]     x_i,
   input  logic [IN_LANES*WW-1:0]     w_i,
   output logic signed [ACC_W-1:0]    acc_nxt_o
);

   localparam int unsigned PW = XW + 1 + WW;

   logic signed [PW-1:0]    prod_d [IN_LANES];
   logic signed [PW-1:0]    prod_q [IN_LANES];
   logic                    prod_vld_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [31:0]      lane_sum;
   logic signed [31:0]      bias_ext;

   // Per-lane product: activation zero-extended to signed, times signed weight.
   always_comb begin
      for (int l = 0; l < IN_LANES; l++) begin
         prod_d[l] = PW'($signed({1'b0, x_i[l*XW +: XW]})) * PW'($signed(w_i[l*WW +: WW]));
      end
   end

   // Product register; the valid flag marks products still owed to the accumulator.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         prod_vld_q <= 1'b0;
         for (int l = 0; l < IN_LANES; l++) prod_q[l] <= '0;
      end else begin
         prod_vld_q <= beat_i;
         if (beat_i) begin
            for (int l = 0; l < IN_LANES; l++) prod_q[l] <= prod_d[l];
         end
      end
   end

   // Lane adder tree and accumulator next state; bias load restarts the neuron.
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < IN_LANES; l++) lane_sum = lane_sum + 32'(prod_q[l]);
      bias_ext = 32'($signed(bias_i)) <<< BIAS_SHIFT;
      acc_d    = acc_q;
      if (bias_load_i) begin
         acc_d = ACC_W'(sat_add(bias_ext, 32'sd0, ACC_W));
      end else if (prod_vld_q) begin
         acc_d = ACC_W'(sat_add(32'(acc_q), lane_sum, ACC_W));
      end
   end

   // Accumulator register.
   always_ff @(posedge CLK) begin
      if (!RST) acc_q <= '0;
      else      acc_q <= acc_d;
   end

   // Next-state value lets the output stage capture neuron 0 in the same cycle as the last add.
   assign acc_nxt_o = acc_d;

endmodule

// File: rtl/qnn_dense_layer.sv
// Fully-connected quantised layer: bias load, streamed MAC over x/w beats, requantise
// and emit one activation per beat. Define QNN_LAYER_ROUND_EN for round-half-up
// requantisation; otherwise results are truncated (floor).
module qnn_dense_layer
   import qnn_pkg::*;
#(
   parameter int unsigned IN_SIZE    = 784,
   parameter int unsigned OUT_SIZE   = 48,
   parameter int unsigned IN_LANES   = 4,
   parameter int unsigned XW         = 4,
   parameter int unsigned WW         = 4,
   parameter int unsigned ACC_W      = 18,
   parameter int unsigned BIAS_SHIFT = 4,
   parameter int unsigned OUT_SHIFT  = 7
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [IN_LANES*XW-1:0]          x_tdata,
   input  logic                            x_tvalid,
   output logic                            x_tready,
   input  logic [OUT_SIZE*IN_LANES*WW-1:0] w_tdata,
   input  logic                            w_tvalid,
   output logic                            w_tready,
   input  logic [OUT_SIZE*WW-1:0]          b_tdata,
   input  logic                            b_tvalid,
   output logic                            b_tready,
   output logic [XW-1:0]                   a_tdata,
   output logic                            a_tvalid,
   output logic                            a_tlast,
   input  logic                            a_tready,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned NBeats    = ceil_div(IN_SIZE, IN_LANES);
   localparam int unsigned BeatW     = cnt_w(NBeats);
   localparam int unsigned IdxW      = cnt_w(OUT_SIZE);
   localparam int unsigned LastLanes = IN_SIZE - (NBeats - 1) * IN_LANES;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(NBeats - 1);
   localparam logic [IdxW-1:0]  LastIdx  = IdxW'(OUT_SIZE - 1);
`ifdef QNN_LAYER_ROUND_EN
   localparam logic RoundEn = 1'b1;
`else
   localparam logic RoundEn = 1'b0;
`endif

   logic [1:0]                      state_q, state_d;
   logic [BeatW-1:0]                beat_q, beat_d;
   logic [IdxW-1:0]                 idx_q, idx_d, sel_idx;
   logic [XW-1:0]                   a_data_q, a_data_d;
   logic                            a_valid_q, a_valid_d;
   logic                            a_last_q, a_last_d;
   logic                            beat_hs, bias_load, a_hs;
   logic [IN_LANES*XW-1:0]          x_m;
   logic [OUT_SIZE*IN_LANES*WW-1:0] w_m;
   logic signed [ACC_W-1:0]         acc_nxt [OUT_SIZE];
   logic signed [ACC_W-1:0]         sel_acc;

   // Handshakes are gated by reset so every ready reads 0 while it is held.
   assign beat_hs   = RST & (state_q == StMac) & x_tvalid & w_tvalid;
   assign x_tready  = beat_hs;
   assign w_tready  = beat_hs;
   assign b_tready  = RST & (state_q == StIdle);
   assign bias_load = b_tready & b_tvalid;
   assign a_hs      = RST & a_valid_q & a_tready;
   assign done      = a_hs & a_last_q;
   assign busy      = RST & (state_q != StIdle);
   assign a_tdata   = a_data_q;
   assign a_tvalid  = a_valid_q;
   assign a_tlast   = a_last_q;

   // Zero lanes past IN_SIZE in the final beat, for both activations and weights.
   always_comb begin
      x_m = x_tdata;
      w_m = w_tdata;
      if (beat_q == LastBeat) begin
         for (int l = 0; l < IN_LANES; l++) begin
            if (l >= LastLanes) begin
               x_m[l*XW +: XW] = '0;
               for (int o = 0; o < OUT_SIZE; o++) w_m[(o*IN_LANES+l)*WW +: WW] = '0;
            end
         end
      end
   end

   for (genvar o = 0; o < OUT_SIZE; o++) begin : g_lane
      qnn_mac_lane #(
         .IN_LANES   (IN_LANES),
         .XW         (XW),
         .WW         (WW),
         .ACC_W      (ACC_W),
         .BIAS_SHIFT (BIAS_SHIFT)
      ) u_lane (
         .CLK         (CLK),
         .RST         (RST),
         .bias_load_i (bias_load),
         .bias_i      (b_tdata[o*WW +: WW]),
         .beat_i      (beat_hs),
         .x_i         (x_m),
         .w_i         (w_m[o*IN_LANES*WW +: IN_LANES*WW]),
         .acc_nxt_o   (acc_nxt[o])
      );
   end

   // Neuron feeding the output register: 0 from DRAIN, the following one during EMIT.
   assign sel_idx = (state_q == StEmit) ? idx_q + 1'b1 : '0;

   // Output neuron mux.
   always_comb begin
      sel_acc = '0;
      for (int o = 0; o < OUT_SIZE; o++) begin
         if (IdxW'(o) == sel_idx) sel_acc = acc_nxt[o];
      end
   end

   // Layer FSM, beat counter and output register next state.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      idx_d     = idx_q;
      a_valid_d = a_valid_q;
      a_last_d  = a_last_q;
      a_data_d  = a_data_q;
      unique case (state_q)
         StIdle: begin
            if (bias_load) begin
               state_d = StMac;
               beat_d  = '0;
            end
         end
         StMac: begin
            if (beat_hs) begin
               if (beat_q == LastBeat) begin
                  state_d = StDrain;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         StDrain: begin
            state_d   = StEmit;
            idx_d     = '0;
            a_valid_d = 1'b1;
            a_last_d  = (LastIdx == '0);
            a_data_d  = XW'(requant(32'(sel_acc), ACC_W, OUT_SHIFT, XW, RoundEn));
         end
         StEmit: begin
            if (a_hs) begin
               if (a_last_q) begin
                  state_d   = StIdle;
                  a_valid_d = 1'b0;
                  a_last_d  = 1'b0;
                  a_data_d  = '0;
               end else begin
                  idx_d    = sel_idx;
                  a_last_d = (sel_idx == LastIdx);
                  a_data_d = XW'(requant(32'(sel_acc), ACC_W, OUT_SHIFT, XW, RoundEn));
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= StIdle;
         beat_q    <= '0;
         idx_q     <= '0;
         a_valid_q <= 1'b0;
         a_last_q  <= 1'b0;
         a_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         idx_q     <= idx_d;
         a_valid_q <= a_valid_d;
         a_last_q  <= a_last_d;
         a_data_q  <= a_data_d;
      end
   end

endmodule
